// File: rtl/levenshtein_search_scheduler.sv
// levenshtein_search_scheduler: walks a zero-terminated word dictionary, streams characters to a comparator and tracks the best edit distance.
module levenshtein_search_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_LEN    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  m_axis_tvalid,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tuser,
  input  logic                  s_axis_tvalid,
  input  logic [7:0]            s_axis_tdata,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            best_distance,
  output logic [15:0]           best_index,
  output logic [15:0]           word_count,
  output logic                  timeout
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [15:0] TO = 16'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, READ, CHECK, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LW-1:0] len;
  logic [15:0] wcnt, wcnt_n;
  logic first, wrap, hit, zero;
  assign wcnt_n   = wcnt + 16'd1;
  assign hit      = wcnt_n == TO;
  assign wrap     = &addr;
  assign zero     = mem_rdata == 8'd0;
  assign mem_rd   = state == READ;
  assign mem_addr = addr;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? READ : IDLE;
      READ:    state_n = CHECK;
      CHECK:   state_n = (zero && first) || wrap ? DONE : zero ? WAIT : READ;
      WAIT:    state_n = s_axis_tvalid ? (s_axis_tdata == 8'd0 ? DONE : READ) : hit ? DONE : WAIT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      addr          <= '0;
      len           <= '0;
      wcnt          <= '0;
      first         <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'd0;
      m_axis_tuser  <= 1'b0;
      best_distance <= 8'hFF;
      best_index    <= 16'd0;
      word_count    <= 16'd0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_n;
      m_axis_tvalid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr          <= base_addr;
          best_distance <= 8'hFF;
          best_index    <= 16'd0;
          word_count    <= 16'd0;
          timeout       <= 1'b0;
          first         <= 1'b1;
          len           <= '0;
        end
        CHECK: if (!zero) begin
          if (len < MAX_L) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= mem_rdata;
            m_axis_tuser  <= first;
            len           <= len + 1'b1;
          end
          first <= 1'b0;
          addr  <= addr + 1'b1;
        end else if (!first) begin
          addr <= addr + 1'b1;
          wcnt <= 16'd0;
        end
        WAIT: if (s_axis_tvalid) begin
          if (s_axis_tdata < best_distance) begin
            best_distance <= s_axis_tdata;
            best_index    <= word_count;
          end
          word_count <= word_count == 16'hFFFF ? word_count : word_count + 16'd1;
          first      <= 1'b1;
          len        <= '0;
        end else begin
          wcnt <= wcnt_n;
          if (hit) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_levenshtein_search_scheduler.sv
// tb_levenshtein_search_scheduler: directed dictionary searches against a byte memory model and a delayed result responder.
module tb_levenshtein_search_scheduler;
  logic aclk = 0, areset = 1, start = 0;
  logic [11:0] base_addr = 0;
  logic mem_rd, m_axis_tvalid, m_axis_tuser, busy, done, timeout;
  logic [11:0] mem_addr;
  logic [7:0] mem_rdata = 0, m_axis_tdata, best_distance;
  logic s_axis_tvalid = 0;
  logic [7:0] s_axis_tdata = 0;
  logic [15:0] best_index, word_count;
  int checks = 0, failures = 0;
  logic [7:0] mem [0:4095];
  logic [7:0] res [0:7];
  int rn = 0, ri = 0, pend = 0;
  logic rd_d = 0, prev_nz = 0;
  int nb, done_cnt, nreads, cyc, rd_cyc, done_cyc, max_rd;
  logic [7:0] bt_data [0:63];
  logic bt_user [0:63];
  logic read_flag;
  logic [11:0] flag_addr, lat_addr;

  levenshtein_search_scheduler dut (
    .aclk(aclk), .areset(areset), .start(start), .base_addr(base_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .busy(busy), .done(done), .best_distance(best_distance), .best_index(best_index),
    .word_count(word_count), .timeout(timeout)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    rd_d <= mem_rd;
  end

  // Answer each completed word three cycles after its terminator is read, while results remain.
  always @(posedge aclk) begin
    s_axis_tvalid <= 1'b0;
    if (pend > 0) pend <= pend - 1;
    if (pend == 1) begin
      s_axis_tvalid <= 1'b1;
      s_axis_tdata  <= res[ri];
      ri <= ri + 1;
    end
    if (rd_d) begin
      if (mem_rdata == 8'd0 && prev_nz && ri < rn) pend <= 3;
      prev_nz <= mem_rdata != 8'd0;
    end
    if (start) begin
      ri <= 0;
      prev_nz <= 1'b0;
      pend <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    cyc++;
    if (mem_rd) begin
      nreads++;
      if (int'(mem_addr) > max_rd) max_rd = int'(mem_addr);
      if (mem_addr == flag_addr) read_flag = 1;
      if (mem_addr == lat_addr) rd_cyc = cyc;
    end
    if (m_axis_tvalid && nb < 64) begin
      bt_data[nb] = m_axis_tdata;
      bt_user[nb] = m_axis_tuser;
      nb++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic launch(input logic [11:0] base);
    nb = 0; done_cnt = 0; nreads = 0; cyc = 0; rd_cyc = -1000; done_cyc = 0; max_rd = 0; read_flag = 0;
    @(negedge aclk);
    start = 1;
    base_addr = base;
    @(negedge aclk);
    start = 0;
  endtask

  task automatic run(input logic [11:0] base, input int budget);
    int n;
    launch(base);
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      sample();
      @(negedge aclk);
      n++;
    end
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL run_timeout got=nodone exp=done base=%0h", base);
    end
    check("busy_after_done", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) begin
      sample();
      @(negedge aclk);
    end
  endtask

  task automatic put(input logic [11:0] a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a + 12'(i)] = s[i];
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    flag_addr = 12'hFFF;
    lat_addr = 12'hFFF;
    repeat (3) @(negedge aclk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_mem_rd", {31'd0, mem_rd}, 0);
    check("rst_mem_addr", {20'd0, mem_addr}, 0);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("rst_best", {24'd0, best_distance}, 32'hFF);
    areset = 0;

    put(12'h010, "AB");
    put(12'h013, "CD");
    res[0] = 3; res[1] = 1; rn = 2;
    run(12'h010, 500);
    check("t1_beats", nb, 4);
    check("t1_c0", {23'd0, bt_user[0], bt_data[0]}, {23'd0, 1'b1, 8'h41});
    check("t1_c1", {23'd0, bt_user[1], bt_data[1]}, {23'd0, 1'b0, 8'h42});
    check("t1_c2", {23'd0, bt_user[2], bt_data[2]}, {23'd0, 1'b1, 8'h43});
    check("t1_c3", {23'd0, bt_user[3], bt_data[3]}, {23'd0, 1'b0, 8'h44});
    check("t1_best", {24'd0, best_distance}, 1);
    check("t1_idx", {16'd0, best_index}, 1);
    check("t1_wc", {16'd0, word_count}, 2);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_timeout", {31'd0, timeout}, 0);

    put(12'h100, "X");
    put(12'h102, "Y");
    put(12'h104, "Z");
    res[0] = 2; res[1] = 0; rn = 2;
    flag_addr = 12'h104;
    run(12'h100, 500);
    check("t2_best", {24'd0, best_distance}, 0);
    check("t2_idx", {16'd0, best_index}, 1);
    check("t2_wc", {16'd0, word_count}, 2);
    check("t2_third_read", {31'd0, read_flag}, 0);
    check("t2_beats", nb, 2);

    put(12'h200, "abcdefghij");
    res[0] = 5; rn = 1;
    flag_addr = 12'hFFF;
    run(12'h200, 500);
    check("t3_beats", nb, 8);
    check("t3_last", {24'd0, bt_data[7]}, 32'h68);
    check("t3_max_addr", max_rd, 32'h20B);
    check("t3_reads", nreads, 12);
    check("t3_wc", {16'd0, word_count}, 1);
    check("t3_best", {24'd0, best_distance}, 5);

    put(12'h400, "Q");
    put(12'h402, "R");
    rn = 0;
    lat_addr = 12'h401;
    run(12'h400, 1000);
    check("t4_timeout", {31'd0, timeout}, 1);
    check("t4_wc", {16'd0, word_count}, 0);
    check("t4_best", {24'd0, best_distance}, 32'hFF);
    check("t4_latency_ok", {31'd0, (done_cyc - (rd_cyc + 1)) >= 255 && (done_cyc - (rd_cyc + 1)) <= 257}, 1);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_held", {31'd0, timeout}, 1);
    lat_addr = 12'hFFF;

    put(12'h500, "M");
    launch(12'h500);
    repeat (20) @(negedge aclk);
    check("t5_busy_pre", {31'd0, busy}, 1);
    #2 areset = 1;
    #1;
    check("t5_rst_busy", {31'd0, busy}, 0);
    check("t5_rst_mem_rd", {31'd0, mem_rd}, 0);
    check("t5_rst_mem_addr", {20'd0, mem_addr}, 0);
    check("t5_rst_tdata", {23'd0, m_axis_tuser, m_axis_tdata}, 0);
    check("t5_rst_timeout", {31'd0, timeout}, 0);
    check("t5_rst_best", {24'd0, best_distance}, 32'hFF);
    repeat (2) @(negedge aclk);
    areset = 0;
    run(12'h600, 100);
    check("t5_reads", nreads, 1);
    check("t5_beats", nb, 0);
    check("t5_best", {24'd0, best_distance}, 32'hFF);
    check("t5_wc", {16'd0, word_count}, 0);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_done_lat", done_cyc, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/levenshtein_search_scheduler.md
LEVENSHTEIN_SEARCH_SCHEDULER -- requirements
Module: levenshtein_search_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: dictionary memory address width.
REQ-002 Parameter MAX_LEN, default 8: maximum characters forwarded per dictionary word.
REQ-003 Parameter TIMEOUT, default 255: cycles allowed between a word's end and its result.
REQ-004 aclk  input  1  sole clock; all state updates on rising edge.
REQ-005 areset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a dictionary search.
REQ-007 base_addr  input  ADDR_WIDTH  first dictionary byte address, sampled on accepted start.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 mem_addr  output  ADDR_WIDTH  memory read address.
REQ-010 mem_rdata  input  8  read data, valid exactly one cycle after mem_rd.
REQ-011 m_axis_tvalid  output  1  character valid toward comparator; no backpressure.
REQ-012 m_axis_tdata  output  8  dictionary character.
REQ-013 m_axis_tuser  output  1  high on the first character of each word.
REQ-014 s_axis_tvalid  input  1  distance result valid from levenshtein stage.
REQ-015 s_axis_tdata  input  8  edit distance of the last completed word.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse at search completion.
REQ-018 best_distance  output  8  smallest distance seen this search.
REQ-019 best_index  output  16  zero-based word index of best_distance.
REQ-020 word_count  output  16  number of words with received results.
REQ-021 timeout  output  1  sticky flag: a result wait expired.

Function
REQ-022 Dictionary format SHALL be: bytes of a word, terminated by 0x00; a 0x00 as first byte of a word ends the dictionary.
REQ-023 States SHALL be IDLE, READ, CHECK, WAIT, DONE.
REQ-024 IDLE: start SHALL load address=base_addr, best_distance=0xFF, best_index=0, word_count=0, timeout=0, first=1, len=0, then go READ; start outside IDLE SHALL be ignored.
REQ-025 READ: mem_rd=1 with mem_addr=address for one cycle, then CHECK; mem_rd SHALL be 0 in all other states.
REQ-026 CHECK, mem_rdata!=0: if len<MAX_LEN, next cycle SHALL assert m_axis_tvalid for exactly one cycle with tdata=mem_rdata, tuser=first; len++ (saturating); first=0; address++; go READ.
REQ-027 Characters beyond MAX_LEN SHALL be consumed (address advanced) but not emitted.
REQ-028 CHECK, mem_rdata==0 and first=1: go DONE.
REQ-029 CHECK, mem_rdata==0 and first=0: address++, clear wait counter, go WAIT.
REQ-030 WAIT, s_axis_tvalid=1: if tdata<best_distance (strict) update best_distance=tdata, best_index=word_count; word_count++ (saturate 0xFFFF); first=1, len=0.
REQ-031 After REQ-030, tdata==0 SHALL go DONE (exact match, early stop); else READ.
REQ-032 WAIT counter reaching TIMEOUT without s_axis_tvalid SHALL set timeout=1 and go DONE.
REQ-033 Address increment wrapping from all-ones to zero SHALL go DONE after the current CHECK action.
REQ-034 s_axis_tvalid outside WAIT SHALL be ignored.
REQ-035 DONE: done=1 for one cycle, busy=0 next cycle, return IDLE; results held until next accepted start.
REQ-036 busy SHALL be 1 in READ, CHECK, WAIT, DONE.

Reset
REQ-037 areset SHALL immediately force IDLE, mem_rd=0, mem_addr=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, busy=0, done=0, best_distance=0xFF, best_index=0, word_count=0, timeout=0, including mid-search.

Verification
REQ-038 Memory "AB\0CD\0\0" at base 0x010, results 3 then 1 -> chars A(tuser=1),B,C(tuser=1),D; best_distance=1, best_index=1, word_count=2, done once.
REQ-039 Results 2,0 for three-word dictionary -> stop after second word, best_distance=0, best_index=1, third word never read.
REQ-040 Word of 10 chars, MAX_LEN=8 -> exactly 8 m_axis_tvalid beats, address advances past all 10 plus terminator.
REQ-041 No s_axis_tvalid after first word, TIMEOUT=255 -> timeout=1, done 256+/-1 cycles after terminator CHECK, word_count=0.
REQ-042 areset asserted during WAIT, then start with empty dictionary ("\0") -> all outputs at reset values, then done after one READ/CHECK, best_distance=0xFF.
